maze_ram_arbiter: RTL and testbench
===================================

// Module: maze_ram_arbiter
// PURPOSE
//  Shares one port of the 512x16 maze dual-port RAM between two requesters.
//  - Display requester: read-only, normally has priority.
//  - Game-logic requester: read or write; protected by a starvation limit.
//  Issues registered RAM commands and routes read data back with a valid strobe.
//  Sits between the maze renderer/game FSM and RAM port A or B; the RAM clock ties to clk.
// PARAMETERS
//  ADDR_W      9   RAM address width (512 words)
//  DATA_W      16  RAM data width
//  RD_LAT      1   RAM read latency in clk edges from command capture to dout valid (1..4)
//  STARVE_LIM  4   consecutive lost cycles after which a pending game request wins (1..15)
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  disp_req     in   1       display read request, held until granted
//  disp_addr    in   ADDR_W  display read address
//  disp_gnt     out  1       1-cycle pulse: display command issued this cycle
//  disp_rvalid  out  1       disp_rdata valid this cycle
//  disp_rdata   out  DATA_W  read data, passthrough of ram_dout
//  game_req     in   1       game request, held until granted
//  game_we      in   1       1=write, 0=read
//  game_addr    in   ADDR_W  game address
//  game_din     in   DATA_W  game write data
//  game_gnt     out  1       1-cycle pulse: game command issued this cycle
//  game_rvalid  out  1       game_rdata valid this cycle (reads only)
//  game_rdata   out  DATA_W  read data, passthrough of ram_dout
//  ram_we       out  1       RAM write enable (wire to the 1-bit we port)
//  ram_addr     out  ADDR_W  RAM address
//  ram_din      out  DATA_W  RAM write data
//  ram_dout     in   DATA_W  RAM read data
// BEHAVIOUR
//  Reset values:
//  - All outputs, the wait counter and the tag pipe are 0 asynchronously on rst_n low.
//  - ram_addr and ram_din also reset to 0.
//  Arbitration at edge E0, sampling disp_req and game_req:
//  - game wins if game_req && (!disp_req || wait_cnt >= STARVE_LIM).
//  - Otherwise display wins if disp_req.
//  - Otherwise idle.
//  Winner command, registered at E0 and driven during cycle E0..E1:
//  - ram_addr/ram_din/ram_we are driven from the winner.
//  - The winner's gnt is high for exactly that cycle.
//  - The RAM captures the command at E1.
//  Idle cycle:
//  - ram_we=0 and both gnt signals are 0.
//  - ram_addr and ram_din hold their previous values.
//  - The display never writes, so ram_we=0 when display wins.
//  Read return:
//  - A tag pipe of depth RD_LAT records {read, owner} per issued command.
//  - The owner's rvalid is high in the cycle when ram_dout holds its data, RD_LAT cycles after its gnt cycle.
//  - Writes produce no rvalid.
//  - At most one rvalid is high in any cycle.
//  Requester rules:
//  - A requester keeps req and its fields stable until it sees gnt.
//  - If req is still high at the edge ending the gnt cycle, that is a new request.
//  - Back-to-back issue at one command per cycle is allowed.
//  wait_cnt (clog2(STARVE_LIM+1) bits, saturating):
//  - +1 each edge where game_req=1 and game is not granted.
//  - Cleared on a game grant or when game_req=0.
//  Simultaneous display and game requests with wait_cnt < STARVE_LIM: display wins and wait_cnt increments.
//  Reset mid-operation: in-flight reads are discarded, with no rvalid after reset release.
//  First arbitration happens at the first edge with rst_n high.
// TESTING
//  1. Reset: assert rst_n=0 mid-read -> all gnt/rvalid/ram_we=0 at once; no rvalid after release.
//  2. Game write addr=9'h005 din=16'hBEEF alone -> game_gnt 1 cycle with ram_we=1, addr 005, din BEEF.
//     Then game read of 005 -> game_rvalid RD_LAT cycles after gnt with game_rdata=16'hBEEF.
//  3. Display reads addr 0..7 continuously, req held -> 8 consecutive disp_gnt.
//     disp_rvalid follows RD_LAT later with matching data and no bubbles.
//  4. Both requesters held high, STARVE_LIM=4 -> grant order D,D,D,D,G,D,D,D,D,G...
//     Game never waits more than 4 cycles.
//  5. Alternate write/read from game while display streams -> no rvalid on write slots.
//     Read data never goes to the wrong requester; one-hot check on rvalid.
//  6. Idle with no requests -> ram_we=0 and ram_addr stable at its last value.

Source files
------------

// File: rtl/maze_ram_arbiter_if.sv
// Bundle of the two requester ports and the shared RAM port around the maze RAM arbiter.
// The slave modport is the arbiter's view. The master modport is the requesters' and RAM's view.
// Widths follow the RAM geometry: ADDR_W address bits and DATA_W data bits.
interface maze_ram_arbiter_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16
);
    // display requester (read-only)
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    // game-logic requester (read or write)
    logic              game_req;
    logic              game_we;
    logic [ADDR_W-1:0] game_addr;
    logic [DATA_W-1:0] game_din;
    logic              game_gnt;
    logic              game_rvalid;
    logic [DATA_W-1:0] game_rdata;
    // shared RAM port
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  disp_req, disp_addr,
        input  game_req, game_we, game_addr, game_din,
        input  ram_dout,
        output disp_gnt, disp_rvalid, disp_rdata,
        output game_gnt, game_rvalid, game_rdata,
        output ram_we, ram_addr, ram_din
    );

    modport master (
        output disp_req, disp_addr,
        output game_req, game_we, game_addr, game_din,
        output ram_dout,
        input  disp_gnt, disp_rvalid, disp_rdata,
        input  game_gnt, game_rvalid, game_rdata,
        input  ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/maze_ram_arbiter.sv
// Shares one maze RAM port between the display (read, priority) and the game logic (read/write, starvation-protected).
// Latency: gnt and the RAM command appear one cycle after req is sampled; rvalid follows RD_LAT cycles after gnt.
// Backpressure: a requester holds req and its fields until it sees gnt. One command is issued per cycle at most.
module maze_ram_arbiter #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_LIM = 4
) (
    input logic                clk,
    input logic                rst_n,
    maze_ram_arbiter_if.slave  bus_if
);
    localparam int unsigned CNT_W = $clog2(STARVE_LIM + 1);

    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_disp_gnt;
    logic              r_game_gnt;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;
    // One bit per pipe stage and owner. A bit is set only for read commands.
    // Each stage therefore holds at most one owner, so the rvalid outputs are one-hot by construction.
    logic [RD_LAT-1:0] r_pipe_disp;
    logic [RD_LAT-1:0] r_pipe_game;

    logic w_starved;
    logic w_game_win;
    logic w_disp_win;

    // Display has priority unless the game has lost STARVE_LIM consecutive cycles
    assign w_starved  = (r_wait_cnt >= CNT_W'(STARVE_LIM));
    assign w_game_win = bus_if.game_req && (!bus_if.disp_req || w_starved);
    assign w_disp_win = bus_if.disp_req && !w_game_win;

    // Register the winning command. Address and data hold on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_gnt <= 1'b0;
            r_game_gnt <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
        end else begin
            r_disp_gnt <= w_disp_win;
            r_game_gnt <= w_game_win;
            r_ram_we   <= w_game_win && bus_if.game_we;
            if (w_game_win) begin
                r_ram_addr <= bus_if.game_addr;
                r_ram_din  <= bus_if.game_din;
            end else if (w_disp_win) begin
                r_ram_addr <= bus_if.disp_addr;
            end
        end
    end

    // Count consecutive cycles the game is pending and loses. The counter saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (bus_if.game_req && !w_game_win) begin
            if (r_wait_cnt != '1) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Track each issued read through the RAM latency so its data returns to the owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_disp <= '0;
            r_pipe_game <= '0;
        end else begin
            r_pipe_disp[0] <= r_disp_gnt;
            r_pipe_game[0] <= r_game_gnt && !r_ram_we;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_pipe_disp[i] <= r_pipe_disp[i-1];
                r_pipe_game[i] <= r_pipe_game[i-1];
            end
        end
    end

    assign bus_if.disp_gnt    = r_disp_gnt;
    assign bus_if.game_gnt    = r_game_gnt;
    assign bus_if.ram_we      = r_ram_we;
    assign bus_if.ram_addr    = r_ram_addr;
    assign bus_if.ram_din     = r_ram_din;
    assign bus_if.disp_rvalid = r_pipe_disp[RD_LAT-1];
    assign bus_if.game_rvalid = r_pipe_game[RD_LAT-1];
    assign bus_if.disp_rdata  = bus_if.ram_dout;
    assign bus_if.game_rdata  = bus_if.ram_dout;
endmodule

// File: tb/tb_maze_ram_arbiter.sv
// Directed bench for maze_ram_arbiter with a synchronous RAM model of latency RD_LAT.
// A negedge monitor tracks issued reads and checks the rvalid routing and data.
// The main sequence covers reset, game write/read, display streaming, starvation, mixed traffic, idle and reset mid-read.
module tb_maze_ram_arbiter;
    localparam int RD_LAT     = 2;
    localparam int STARVE_LIM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    maze_ram_arbiter_if #(.ADDR_W(9), .DATA_W(16)) bus();

    maze_ram_arbiter #(
        .ADDR_W(9), .DATA_W(16), .RD_LAT(RD_LAT), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // RAM model: read-before-write, data valid RD_LAT edges after the command is captured
    logic [15:0] mem    [512];
    logic [15:0] shadow [512];
    logic [15:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        rd_pipe[0] <= mem[bus.ram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.ram_dout = rd_pipe[RD_LAT-1];

    // Read-return monitor
    typedef struct {
        int          due;
        bit          game;
        logic [15:0] data;
    } rd_t;
    rd_t exp_q[$];
    rd_t mon_e;
    int  cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                mon_e = exp_q.pop_front();
                check_eq("mon_disp_rvalid", 32'(bus.disp_rvalid), 32'(!mon_e.game));
                check_eq("mon_game_rvalid", 32'(bus.game_rvalid), 32'(mon_e.game));
                check_eq("mon_rdata", 32'(mon_e.game ? bus.game_rdata : bus.disp_rdata), 32'(mon_e.data));
            end else begin
                check_eq("mon_no_rvalid", 32'({bus.disp_rvalid, bus.game_rvalid}), 32'(0));
            end
            check_eq("mon_gnt_onehot", 32'(bus.disp_gnt && bus.game_gnt), 32'(0));
            if (bus.disp_gnt)
                exp_q.push_back('{cyc + RD_LAT, 1'b0, shadow[bus.ram_addr]});
            if (bus.game_gnt) begin
                if (bus.ram_we) shadow[bus.ram_addr] = bus.ram_din;
                else exp_q.push_back('{cyc + RD_LAT, 1'b1, shadow[bus.ram_addr]});
            end
        end
    end

    int  op;
    bit  exp_g;

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]    = 16'hA000 + 16'(i);
            shadow[i] = 16'hA000 + 16'(i);
        end
        bus.disp_req = 0; bus.disp_addr = '0;
        bus.game_req = 0; bus.game_we = 0; bus.game_addr = '0; bus.game_din = '0;

        // Reset values
        #12;
        check_eq("rst_disp_gnt", 32'(bus.disp_gnt), 0);
        check_eq("rst_game_gnt", 32'(bus.game_gnt), 0);
        check_eq("rst_rvalid",   32'({bus.disp_rvalid, bus.game_rvalid}), 0);
        check_eq("rst_ram_we",   32'(bus.ram_we), 0);
        check_eq("rst_ram_addr", 32'(bus.ram_addr), 0);
        check_eq("rst_ram_din",  32'(bus.ram_din), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;

        // Game write of BEEF to 005, then read it back
        bus.game_req = 1; bus.game_we = 1; bus.game_addr = 9'h005; bus.game_din = 16'hBEEF;
        @(negedge clk);
        check_eq("t2_wr_gnt",  32'(bus.game_gnt), 1);
        check_eq("t2_wr_dgnt", 32'(bus.disp_gnt), 0);
        check_eq("t2_wr_we",   32'(bus.ram_we), 1);
        check_eq("t2_wr_addr", 32'(bus.ram_addr), 32'h005);
        check_eq("t2_wr_din",  32'(bus.ram_din), 32'hBEEF);
        bus.game_req = 0;
        @(negedge clk);
        check_eq("t2_idle_gnt",  32'(bus.game_gnt), 0);
        check_eq("t2_idle_we",   32'(bus.ram_we), 0);
        check_eq("t2_idle_addr", 32'(bus.ram_addr), 32'h005);
        bus.game_req = 1; bus.game_we = 0;
        @(negedge clk);
        check_eq("t2_rd_gnt", 32'(bus.game_gnt), 1);
        check_eq("t2_rd_we",  32'(bus.ram_we), 0);
        bus.game_req = 0;
        @(negedge clk);
        check_eq("t2_rv_early", 32'(bus.game_rvalid), 0);
        @(negedge clk);
        check_eq("t2_rvalid", 32'(bus.game_rvalid), 1);
        check_eq("t2_rdata",  32'(bus.game_rdata), 32'hBEEF);
        check_eq("t2_drv",    32'(bus.disp_rvalid), 0);
        repeat (2) @(negedge clk);

        // Display streams addresses 0..7 with req held
        bus.disp_req = 1; bus.disp_addr = 9'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 8) begin
                check_eq("t3_gnt",  32'(bus.disp_gnt), 1);
                check_eq("t3_addr", 32'(bus.ram_addr), 32'(i));
                check_eq("t3_we",   32'(bus.ram_we), 0);
            end
            if (i >= RD_LAT) begin
                check_eq("t3_rvalid", 32'(bus.disp_rvalid), 1);
                check_eq("t3_rdata",  32'(bus.disp_rdata),
                         (i - RD_LAT == 5) ? 32'hBEEF : 32'hA000 + 32'(i - RD_LAT));
            end
            if (i < 7) bus.disp_addr = 9'(i + 1);
            else bus.disp_req = 0;
        end
        repeat (2) @(negedge clk);

        // Both held: D,D,D,D,G repeating
        bus.disp_req = 1; bus.disp_addr = 9'h008;
        bus.game_req = 1; bus.game_we = 0; bus.game_addr = 9'h009;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            exp_g = (i % 5 == 4);
            check_eq("t4_dgnt", 32'(bus.disp_gnt), 32'(!exp_g));
            check_eq("t4_ggnt", 32'(bus.game_gnt), 32'(exp_g));
            check_eq("t4_addr", 32'(bus.ram_addr), exp_g ? 32'h009 : 32'h008);
        end
        bus.disp_req = 0; bus.game_req = 0;
        repeat (4) @(negedge clk);

        // Game alternates write/read while the display streams
        bus.disp_req = 1; bus.disp_addr = 9'h00A;
        op = 0;
        bus.game_req = 1; bus.game_we = 1; bus.game_addr = 9'd20; bus.game_din = 16'h1234;
        for (int c = 0; c < 40 && op < 4; c++) begin
            @(negedge clk);
            if (bus.game_gnt) begin
                check_eq("t5_we",   32'(bus.ram_we), 32'(op % 2 == 0));
                check_eq("t5_addr", 32'(bus.ram_addr), 32'(20 + op / 2));
                if (op == 0) check_eq("t5_din0", 32'(bus.ram_din), 32'h1234);
                if (op == 2) check_eq("t5_din2", 32'(bus.ram_din), 32'h5678);
                op++;
                if (op < 4) begin
                    bus.game_we   = (op % 2 == 0);
                    bus.game_addr = 9'(20 + op / 2);
                    bus.game_din  = 16'h5678;
                end else begin
                    bus.game_req = 0;
                end
            end else if (bus.disp_gnt) begin
                check_eq("t5_disp_we", 32'(bus.ram_we), 0);
            end
        end
        check_eq("t5_ops_done", 32'(op), 4);
        bus.disp_req = 0;
        repeat (4) @(negedge clk);

        // Idle after a display read of 1FF: address and data hold
        bus.disp_req = 1; bus.disp_addr = 9'h1FF;
        @(negedge clk);
        check_eq("t6_gnt",  32'(bus.disp_gnt), 1);
        check_eq("t6_addr", 32'(bus.ram_addr), 32'h1FF);
        bus.disp_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t6_idle_we",   32'(bus.ram_we), 0);
            check_eq("t6_idle_gnt",  32'({bus.disp_gnt, bus.game_gnt}), 0);
            check_eq("t6_idle_addr", 32'(bus.ram_addr), 32'h1FF);
            check_eq("t6_idle_din",  32'(bus.ram_din), 32'h5678);
        end

        // Reset during an in-flight game read
        bus.game_req = 1; bus.game_we = 0; bus.game_addr = 9'h005;
        @(negedge clk);
        check_eq("t1_gnt", 32'(bus.game_gnt), 1);
        #1 rst_n = 0;
        #1;
        check_eq("t1_rst_gnt",    32'({bus.disp_gnt, bus.game_gnt}), 0);
        check_eq("t1_rst_rvalid", 32'({bus.disp_rvalid, bus.game_rvalid}), 0);
        check_eq("t1_rst_we",     32'(bus.ram_we), 0);
        check_eq("t1_rst_addr",   32'(bus.ram_addr), 0);
        bus.game_req = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        bus.disp_req = 1; bus.disp_addr = 9'h003;
        @(negedge clk);
        check_eq("t1_first_gnt", 32'(bus.disp_gnt), 1);
        bus.disp_req = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t1_no_game_rv", 32'(bus.game_rvalid), 0);
        end
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
